// File: rtl/clkdiv_pkg.sv
// Shared definitions for the integer clock divider: ratio limits, duty split
// helper and the elaboration-time legality check.
package clkdiv_pkg;

  localparam int unsigned DIV_MIN = 2;
  localparam int unsigned DIV_MAX = 65535;

  typedef enum logic {
    DIV_EVEN = 1'b0,
    DIV_ODD  = 1'b1
  } div_parity_e;

  function automatic div_parity_e div_parity(input int unsigned n);
    return n[0] ? DIV_ODD : DIV_EVEN;
  endfunction

  // Whole clk periods that pos_q stays high: N/2 (even) or (N-1)/2 (odd).
  function automatic int unsigned half_high(input int unsigned n);
    return n / 2;
  endfunction

  function automatic bit div_ok(input int unsigned n);
    return (n >= DIV_MIN) && (n <= DIV_MAX);
  endfunction

endpackage

// File: rtl/clkdiv_if.sv
// Phase bus between the modulo-N counter and the output stage.
interface clkdiv_if #(
  parameter int unsigned CNT_W = 2
);
  logic [CNT_W-1:0] cnt;
  logic             wrap;

  modport master (output cnt, output wrap);
  modport slave  (input cnt, input wrap);
endinterface

// File: rtl/clkdiv_phase_cnt.sv
// Modulo-N phase counter with synchronous reset; wrap marks the N-1 phase.
module clkdiv_phase_cnt #(
  parameter int unsigned DIVISOR = 4,
  parameter int unsigned CNT_W   = $clog2(DIVISOR)
) (
  input  logic      clk,
  input  logic      rst,
  clkdiv_if.master  phase
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] cnt;
  logic             at_last;

  always_comb at_last = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (at_last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign phase.cnt  = cnt;
  assign phase.wrap = at_last;

endmodule

// File: rtl/clock_divider.sv
// Fixed-ratio 50 %-duty clock divider; odd ratios add a falling-edge flop
// so the high time is (N-1)/2 + 0.5 clk periods.
module clock_divider
  import clkdiv_pkg::*;
#(
  parameter int unsigned DIVISOR = 4,
  parameter int unsigned CNT_W   = $clog2(DIVISOR)
) (
  input  logic clk,
  input  logic rst,
  output logic clk_out
);

  if (!div_ok(DIVISOR)) begin : g_bad_divisor
    $error("clock_divider: DIVISOR %0d outside %0d..%0d", DIVISOR, DIV_MIN, DIV_MAX);
  end
  if (CNT_W != $clog2(DIVISOR)) begin : g_bad_cnt_w
    $error("clock_divider: CNT_W must stay at $clog2(DIVISOR)");
  end

  localparam logic [CNT_W-1:0] K = CNT_W'(half_high(DIVISOR));

  clkdiv_if #(.CNT_W(CNT_W)) phase_bus ();

  clkdiv_phase_cnt #(
    .DIVISOR (DIVISOR),
    .CNT_W   (CNT_W)
  ) u_phase_cnt (
    .clk   (clk),
    .rst   (rst),
    .phase (phase_bus.master)
  );

  logic pos_d;
  logic pos_q;

  // High for the first K phases of each period, starting on the first edge out of reset.
  always_comb pos_d = (phase_bus.cnt < K) && !phase_bus.wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
    end
  end

  if (div_parity(DIVISOR) == DIV_EVEN) begin : g_even
    assign clk_out = pos_q;
  end else begin : g_odd
    logic rst_q;
    logic neg_q;

    always_ff @(posedge clk) begin
      rst_q <= rst;
    end

    always_ff @(negedge clk) begin
      if (rst_q) begin
        neg_q <= 1'b0;
      end else begin
        neg_q <= pos_q;
      end
    end

    // rst_q masks neg_q so a reset edge forces the output low at once
    // instead of waiting for the next falling edge to clear neg_q.
    assign clk_out = pos_q | (neg_q & ~rst_q);
  end

endmodule

// File: tb/tb_clock_divider.sv
// Bench for clock_divider: five ratios side by side against a half-cycle
// position model, plus directed literal checks.
module tb_clock_divider;

  localparam int unsigned NDUT = 5;
  localparam int unsigned NS [NDUT] = '{4, 2, 3, 5, 65535};

  logic            clk;
  logic [NDUT-1:0] rst;
  logic            o0, o1, o2, o3, o4;
  logic [NDUT-1:0] outs;

  int unsigned r [NDUT];
  int          n_assert;
  int          n_fail;

  clock_divider #(.DIVISOR(4))     u_d4     (.clk(clk), .rst(rst[0]), .clk_out(o0));
  clock_divider #(.DIVISOR(2))     u_d2     (.clk(clk), .rst(rst[1]), .clk_out(o1));
  clock_divider #(.DIVISOR(3))     u_d3     (.clk(clk), .rst(rst[2]), .clk_out(o2));
  clock_divider #(.DIVISOR(5))     u_d5     (.clk(clk), .rst(rst[3]), .clk_out(o3));
  clock_divider #(.DIVISOR(65535)) u_d65535 (.clk(clk), .rst(rst[4]), .clk_out(o4));

  always_comb outs = {o4, o3, o2, o1, o0};

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // rr = rising edges since reset release; p = 0 after the rising edge, 1 after the falling edge.
  // The output is high for the first N half-cycles of every 2N.
  function automatic logic model_out(input int unsigned n, input int unsigned rr, input int unsigned p);
    int unsigned t;
    if (rr == 0) return 1'b0;
    t = 2 * (rr - 1) + p;
    return ((t % (2 * n)) < n) ? 1'b1 : 1'b0;
  endfunction

  task automatic lit(input string name, input logic got, input logic want);
    n_assert++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, got, want);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    for (int i = 0; i < NDUT; i++) r[i] = 0;
  end

  // Model compare every half cycle.
  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < NDUT; i++) r[i] = rst[i] ? 0 : r[i] + 1;
      #1;
      for (int i = 0; i < NDUT; i++) begin
        n_assert++;
        if (outs[i] !== model_out(NS[i], r[i], 0)) begin
          n_fail++;
          $display("FAIL model_rise N=%0d at %0t: got %b want %b", NS[i], $time, outs[i],
                   model_out(NS[i], r[i], 0));
        end
      end
      @(negedge clk);
      #1;
      for (int i = 0; i < NDUT; i++) begin
        n_assert++;
        if (outs[i] !== model_out(NS[i], r[i], 1)) begin
          n_fail++;
          $display("FAIL model_fall N=%0d at %0t: got %b want %b", NS[i], $time, outs[i],
                   model_out(NS[i], r[i], 1));
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] e4;
    logic [4:0] e2;
    logic [4:0] e3;
    bit         found;
    e4 = 5'b10011;
    e2 = 5'b10101;
    e3 = 5'b11011;
    rst = '1;

    // Long reset: every output pinned low.
    repeat (100) begin
      @(posedge clk);
      #3;
      for (int i = 0; i < NDUT; i++) lit("reset_hold_low", outs[i], 1'b0);
    end

    @(negedge clk);
    #5;
    rst = '0;

    // First five rising edges after release.
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #3;
      lit("n4_after_release", outs[0], e4[k]);
      lit("n2_after_release", outs[1], e2[k]);
      lit("n3_after_release", outs[2], e3[k]);
      if (k < 2) begin
        @(negedge clk);
        #3;
        lit("n3_fall_phase", outs[2], (k == 0) ? 1'b1 : 1'b0);
      end
    end

    // N=5: reset pulse in the high phase, just after the rise.
    found = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      @(posedge clk);
      #3;
      if (r[3] % 5 == 1) found = 1'b1;
    end
    n_assert++;
    if (!found) begin
      n_fail++;
      $display("FAIL n5_find_high_phase: got none want phase 1 within 12 cycles");
    end
    @(negedge clk);
    #5;
    rst[3] = 1'b1;
    @(posedge clk);
    #3;
    lit("n5_mid_reset_low", outs[3], 1'b0);
    @(negedge clk);
    #3;
    lit("n5_mid_reset_fall_low", outs[3], 1'b0);
    #2;
    rst[3] = 1'b0;
    @(posedge clk);
    #3;
    lit("n5_restart_rise", outs[3], 1'b1);

    // Random resets on the small ratios; the 65535 divider runs free for a full period.
    for (int c = 0; c < 65600; c++) begin
      @(negedge clk);
      #5;
      if (r[4] == 32767) lit("n65535_high_end", outs[4], 1'b1);
      if (r[4] == 32768) lit("n65535_first_low", outs[4], 1'b0);
      if (r[4] == 65535) lit("n65535_low_end", outs[4], 1'b0);
      if (r[4] == 65536) lit("n65535_second_rise", outs[4], 1'b1);
      for (int i = 0; i < 4; i++) begin
        if (rst[i]) rst[i] = ($urandom_range(0, 2) == 0);
        else        rst[i] = ($urandom_range(0, 49) == 0);
      end
    end

    @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
